// File: rtl/square_bounce.sv
// Bouncing-squares painter: N_SQ squares move diagonally, bounce off the screen edges, registered RGB out.
// Optional background flash on bounce frames when SQUARE_BOUNCE_FLASH_EN is defined.
module square_bounce #(
    parameter int          CORDW   = 12,
    parameter int          H_RES   = 1920,
    parameter int          V_RES   = 1080,
    parameter int          N_SQ    = 2,
    parameter int          Q_SIZE  = 96,
    parameter int          SPEED   = 1,
    parameter logic [23:0] COLR_SQ = 24'hFF8800,
    parameter logic [23:0] COLR_BG = 24'h0088FF
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             run,
    input  logic             frame,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    output logic             de_q,
    output logic             hsync_q,
    output logic             vsync_q,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);
    // One extra bit so position+step and position+size never wrap.
    localparam int            XW    = CORDW + 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - Q_SIZE);
    localparam logic [XW-1:0] Y_MAX = XW'(V_RES - Q_SIZE);
    localparam logic [XW-1:0] STEP  = XW'(SPEED);
    localparam logic [XW-1:0] SIZE  = XW'(Q_SIZE);

    typedef struct packed {
        logic [CORDW-1:0] pos;
        logic             dir;
    } axis_t;

    function automatic axis_t axis_step(input logic [CORDW-1:0] pos, input logic dir,
                                        input logic [XW-1:0] lim);
        logic [XW-1:0] p, sum, dif;
        axis_t         r;
        p   = {1'b0, pos};
        sum = p + STEP;
        dif = p - STEP;
        r   = '{pos: pos, dir: dir};
        if (dir) begin
            if (sum > lim) r = '{pos: CORDW'(lim), dir: 1'b0};
            else           r.pos = CORDW'(sum);
        end else begin
            if (p < STEP)  r = '{pos: '0, dir: 1'b1};
            else           r.pos = CORDW'(dif);
        end
        return r;
    endfunction

    logic [CORDW-1:0] x     [N_SQ];
    logic [CORDW-1:0] y     [N_SQ];
    logic [CORDW-1:0] x_nxt [N_SQ];
    logic [CORDW-1:0] y_nxt [N_SQ];
    logic [N_SQ-1:0]  dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic             frame_r, upd, any_hit;
    logic [23:0]      colr_bg, rgb;

    assign upd = frame & ~frame_r & run;

    always_comb begin
        for (int i = 0; i < N_SQ; i++) begin
            {x_nxt[i], dir_x_nxt[i]} = axis_step(x[i], dir_x[i], X_MAX);
            {y_nxt[i], dir_y_nxt[i]} = axis_step(y[i], dir_y[i], Y_MAX);
        end
    end

    // NOTE: position arrays are plain registers, so they take the async reset like any flop.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            frame_r <= 1'b0;
            dir_x   <= '1;
            dir_y   <= '1;
            for (int i = 0; i < N_SQ; i++) begin
                x[i] <= CORDW'(i * 2 * Q_SIZE);
                y[i] <= CORDW'(i * Q_SIZE);
            end
        end else begin
            frame_r <= frame;
            if (upd) begin
                dir_x <= dir_x_nxt;
                dir_y <= dir_y_nxt;
                for (int i = 0; i < N_SQ; i++) begin
                    x[i] <= x_nxt[i];
                    y[i] <= y_nxt[i];
                end
            end
        end
    end

`ifdef SQUARE_BOUNCE_FLASH_EN
    // A direction flip on any axis is exactly a bounce.
    logic flash;
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)   flash <= 1'b0;
        else if (upd) flash <= (|(dir_x ^ dir_x_nxt)) | (|(dir_y ^ dir_y_nxt));
    end
    assign colr_bg = flash ? 24'hFFFFFF : COLR_BG;
`else
    assign colr_bg = COLR_BG;
`endif

    // NOTE: default first so no path through the loop leaves any_hit unassigned (no latch).
    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < N_SQ; i++) begin
            if (({1'b0, sx} >= {1'b0, x[i]}) && ({1'b0, sx} < {1'b0, x[i]} + SIZE) &&
                ({1'b0, sy} >= {1'b0, y[i]}) && ({1'b0, sy} < {1'b0, y[i]} + SIZE))
                any_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            rgb     <= '0;
        end else begin
            de_q    <= de;
            hsync_q <= hsync;
            vsync_q <= vsync;
            rgb     <= !de ? 24'h000000 : (any_hit ? COLR_SQ : colr_bg);
        end
    end

    assign {red, green, blue} = rgb;

endmodule
